// File: rtl/peripheral_subtractor_if.sv
// Register-side handshake bundle for the bit-serial subtractor.
interface peripheral_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  // Host side: issues requests, observes results.
  modport master (
    output start, x, y, bin,
    input  diff, bout, ovf, busy, done
  );

  // Subtractor side: accepts requests, produces results.
  modport slave (
    input  start, x, y, bin,
    output diff, bout, ovf, busy, done
  );
endinterface

// File: rtl/peripheral_subtractor.sv
// Bit-serial subtractor: diff = x - y - bin, LSB first, one bit per clock,
// using a single full-subtractor cell and operand/result shift registers.
module peripheral_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  peripheral_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_next;
  logic             d;
  logic             xs;
  logic             ys;
  logic             last_bit;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  // Full-subtractor cell on the current LSBs plus the shifted result word.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    d                = a[0] ^ b[0] ^ br;
    br_next          = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
    sr_next          = sr >> 1;
    sr_next[WIDTH-1] = d;
    last_bit         = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM plus operand, borrow, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are plain flops, not a memory, so they are cleared here too.
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      sr     <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      xs     <= 1'b0;
      ys     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      case (state)
        IDLE: begin
          if (bus.start) begin
            a     <= bus.x;
            b     <= bus.y;
            br    <= bus.bin;
            cnt   <= '0;
            xs    <= bus.x[WIDTH-1];
            ys    <= bus.y[WIDTH-1];
            state <= RUN;
          end
        end
        RUN: begin
          a   <= a >> 1;
          b   <= b >> 1;
          br  <= br_next;
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // Results are published only here, so they hold between operations.
            diff_q <= sr_next;
            bout_q <= br_next;
            ovf_q  <= (xs != ys) && (sr_next[WIDTH-1] != xs);
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

endmodule
